// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ST_OP,
      ADDR,
      TA,
      DATA,
      DONE
   } mdio_state_e;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;

   localparam int PRE_LEN  = 32;
   localparam int STOP_LEN = 4;
   localparam int ADDR_LEN = 10;
   localparam int TA_LEN   = 2;
   localparam int DATA_LEN = 16;

   // Number of MDC bit periods spent in each frame state.
   function automatic logic [5:0] state_len(input mdio_state_e s);
      case (s)
         PRE:     return 6'(PRE_LEN);
         ST_OP:   return 6'(STOP_LEN);
         ADDR:    return 6'(ADDR_LEN);
         TA:      return 6'(TA_LEN);
         DATA:    return 6'(DATA_LEN);
         default: return 6'd1;
      endcase
   endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: DIV clk per half period, idle low, with strobes on the
// clk edges that will raise (rise_stb) and lower (fall_stb) mdc.
module mdio_mdc_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic run,
   output logic mdc,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] div_cnt;
   logic          term;

   assign term     = run && (div_cnt == CW'(DIV - 1));
   assign rise_stb = term & ~mdc;
   assign fall_stb = term & mdc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt <= '0;
         mdc     <= 1'b0;
      end else if (clr) begin
         div_cnt <= '0;
         mdc     <= 1'b0;
      end else if (run) begin
         if (term) begin
            div_cnt <= '0;
            mdc     <= ~mdc;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO station master: one read/write frame per accepted command.
// Optional MDIO_PRE_SUPPRESS_EN adds a pre_suppress input that skips the preamble.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        soft_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic [4:0]  cmd_phyad,
   input  logic [4:0]  cmd_regad,
   input  logic [15:0] cmd_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
   input  logic        pre_suppress,
`endif
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   mdio_state_e state, state_nx;
   logic [5:0]  bit_cnt;
   logic [31:0] tx_sr;
   logic [15:0] rx_sr;
   logic        rd_q;
   logic        err_q;
   logic [31:0] frame;
   logic        accept;
   logic        run;
   logic        last_bit;
   logic        skip_pre;
   logic        fall_stb;
   logic        rise_stb;
   logic        tx_bit;
   logic        drv_o;
   logic        drv_oe;

`ifdef MDIO_PRE_SUPPRESS_EN
   assign skip_pre = pre_suppress;
`else
   assign skip_pre = 1'b0;
`endif

   assign cmd_ready = (state == IDLE) & ~soft_reset;
   assign accept    = cmd_valid & cmd_ready;
   assign busy      = (state != IDLE);
   assign run       = (state != IDLE) && (state != DONE);
   assign last_bit  = (bit_cnt == state_len(state) - 6'd1);
   assign frame     = {MDIO_ST, (cmd_rd ? MDIO_OP_RD : MDIO_OP_WR),
                       cmd_phyad, cmd_regad, MDIO_TA_WR, cmd_wdata};

   mdio_mdc_gen #(
      .DIV(DIV)
   ) u_mdc_gen (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (soft_reset | accept),
      .run      (run),
      .mdc      (mdc),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   always_comb begin
      state_nx = state;
      if (soft_reset) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nx = skip_pre ? ST_OP : PRE;
            PRE:     if (fall_stb && last_bit) state_nx = ST_OP;
            ST_OP:   if (fall_stb && last_bit) state_nx = ADDR;
            ADDR:    if (fall_stb && last_bit) state_nx = TA;
            TA:      if (fall_stb && last_bit) state_nx = DATA;
            DATA:    if (fall_stb && last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Pad value for the bit that begins on this edge. The PRE->ST_OP edge
   // presents tx_sr[31] unshifted; every later bit edge looks one ahead.
   always_comb begin
      tx_bit = (state == IDLE) ? frame[31] :
               ((state == PRE) ? tx_sr[31] : tx_sr[30]);
      drv_o  = 1'b1;
      drv_oe = 1'b0;
      case (state_nx)
         PRE: begin
            drv_o  = 1'b1;
            drv_oe = 1'b1;
         end
         ST_OP, ADDR: begin
            drv_o  = tx_bit;
            drv_oe = 1'b1;
         end
         TA, DATA: begin
            if (!rd_q) begin
               drv_o  = tx_bit;
               drv_oe = 1'b1;
            end
         end
         default: begin
            drv_o  = 1'b1;
            drv_oe = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         rsp_valid <= (state == DATA) && (state_nx == DONE);
         if (soft_reset) begin
            bit_cnt   <= '0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end else begin
            if (accept) begin
               bit_cnt <= '0;
            end else if (fall_stb) begin
               bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
            end
            if (accept || fall_stb) begin
               mdio_o  <= drv_o;
               mdio_oe <= drv_oe;
            end
            if ((state == DATA) && (state_nx == DONE) && rd_q) begin
               rsp_rdata <= rx_sr;
               rsp_err   <= err_q;
            end
         end
      end
   end

   // Frame shift registers; only meaningful between accept and DONE.
   always_ff @(posedge clk) begin
      if (accept) begin
         tx_sr <= frame;
         rd_q  <= cmd_rd;
         err_q <= 1'b0;
      end else begin
         if (fall_stb && (state != PRE)) begin
            tx_sr <= {tx_sr[30:0], 1'b0};
         end
         if (rise_stb && (state == TA) && (bit_cnt == 6'd1)) begin
            err_q <= mdio_i;
         end
         if (rise_stb && (state == DATA)) begin
            rx_sr <= {rx_sr[14:0], mdio_i};
         end
      end
   end

endmodule
